// File: rtl/amba_apb_slave_mem_pkg.sv
// Shared types and constants for the APB completer memory.
package amba_apb_pkg;
   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;
   localparam int WAIT_CNT_W = 4;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;
endpackage

// File: rtl/amba_apb_slave_mem_if.sv
// APB3 bus bundle between a requester and the memory completer.
interface amba_apb_slave_mem_if
   import amba_apb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic [DATA_W-1:0] prdata;
   logic              pready;
   logic              pslverr;

   modport master (output psel, penable, pwrite, paddr, pwdata,
                   input  prdata, pready, pslverr);
   modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                   output prdata, pready, pslverr);
endinterface

// File: rtl/amba_apb_slave_mem_regfile.sv
// Storage array: synchronous clear, one write port, combinational read port.
module amba_apb_slave_regfile
   import amba_apb_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MEM_DEPTH = 64,
   parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [IDX_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [MEM_DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Guards a non power-of-two depth; out-of-range reads are flagged as errors upstream.
   assign rdata = (int'(raddr) < MEM_DEPTH) ? mem[raddr] : '0;
endmodule

// File: rtl/amba_apb_slave_mem.sv
// APB3 completer over a small register file with programmable wait states.
// Outputs are decoded from registered state only; request fields are latched at SETUP.
module amba_apb_slave_mem
   import amba_apb_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int MEM_DEPTH   = 64,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                 pclk,
   input  logic                 preset,
   amba_apb_slave_mem_if.slave  bus
);
   localparam int              IDX_W     = $clog2(MEM_DEPTH);
   localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(MEM_DEPTH);

   apb_state_e            state, state_nxt;
   logic [WAIT_CNT_W-1:0] wait_cnt, wait_nxt;
   logic [ADDR_W-1:0]     addr_q;
   logic [DATA_W-1:0]     data_q;
   logic                  dir_q;
   logic                  latch, we, ready, err;
   logic [DATA_W-1:0]     rdata;

   assign latch = (state == IDLE) && bus.psel && !bus.penable;

   always_ff @(posedge pclk) begin
      if (preset) begin
         state    <= IDLE;
         wait_cnt <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         dir_q    <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         if (latch) begin
            addr_q <= bus.paddr;
            data_q <= bus.pwdata;
            dir_q  <= bus.pwrite;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      wait_nxt  = wait_cnt;
      we        = 1'b0;
      case (state)
         IDLE: begin
            if (latch) begin
               state_nxt = SETUP;
               wait_nxt  = WAIT_CNT_W'(WAIT_CYCLES);
            end
         end
         SETUP: begin
            if (!bus.psel)        state_nxt = IDLE;
            else if (bus.penable) state_nxt = ACCESS;
         end
         ACCESS: begin
            // Any loss of psel/penable aborts without touching memory.
            if (!(bus.psel && bus.penable)) begin
               state_nxt = IDLE;
            end else if (wait_cnt == '0) begin
               state_nxt = IDLE;
               we        = dir_q && !err;
            end else begin
               wait_nxt = wait_cnt - 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign ready       = (state == ACCESS) && (wait_cnt == '0);
   assign err         = {1'b0, addr_q} >= DEPTH_LIM;
   assign bus.pready  = ready;
   assign bus.pslverr = ready && err;
   assign bus.prdata  = (ready && !dir_q && !err) ? rdata : '0;

   amba_apb_slave_regfile #(
      .DATA_W    (DATA_W),
      .MEM_DEPTH (MEM_DEPTH),
      .IDX_W     (IDX_W)
   ) u_regfile (
      .clk   (pclk),
      .rst   (preset),
      .we    (we),
      .waddr (addr_q[IDX_W-1:0]),
      .wdata (data_q),
      .raddr (addr_q[IDX_W-1:0]),
      .rdata (rdata)
   );
endmodule

// File: tb/tb_amba_apb_slave_mem.sv
// Bench for amba_apb_slave_mem: a WAIT_CYCLES=0 and a WAIT_CYCLES=3 instance against an array model.
module tb_amba_apb_slave_mem;
   logic       clk = 1'b0;
   logic       preset;
   logic       psel, penable, pwrite;
   logic [7:0] paddr, pwdata;
   logic       dsel;   // 0 -> dut0 (no waits), 1 -> dut3 (3 waits)

   always #5 clk = ~clk;

   amba_apb_slave_mem_if #(.ADDR_W(8), .DATA_W(8)) bus0 ();
   amba_apb_slave_mem_if #(.ADDR_W(8), .DATA_W(8)) bus3 ();

   assign bus0.psel    = psel && !dsel;
   assign bus0.penable = penable && !dsel;
   assign bus0.pwrite  = pwrite;
   assign bus0.paddr   = paddr;
   assign bus0.pwdata  = pwdata;
   assign bus3.psel    = psel && dsel;
   assign bus3.penable = penable && dsel;
   assign bus3.pwrite  = pwrite;
   assign bus3.paddr   = paddr;
   assign bus3.pwdata  = pwdata;

   amba_apb_slave_mem #(.ADDR_W(8), .DATA_W(8), .MEM_DEPTH(64), .WAIT_CYCLES(0)) dut0 (
      .pclk(clk), .preset(preset), .bus(bus0.slave));
   amba_apb_slave_mem #(.ADDR_W(8), .DATA_W(8), .MEM_DEPTH(64), .WAIT_CYCLES(3)) dut3 (
      .pclk(clk), .preset(preset), .bus(bus3.slave));

   logic       pready_m, pslverr_m;
   logic [7:0] prdata_m;
   assign pready_m  = dsel ? bus3.pready  : bus0.pready;
   assign pslverr_m = dsel ? bus3.pslverr : bus0.pslverr;
   assign prdata_m  = dsel ? bus3.prdata  : bus0.prdata;

   logic [7:0] ref_mem [2][64];
   int errors = 0;
   int checks = 0;
   int out_viol = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Outside a completing cycle the response must be fully quiet.
   always @(negedge clk) begin
      if (!preset) begin
         if (!bus0.pready && (bus0.pslverr !== 1'b0 || bus0.prdata !== 8'h00)) out_viol++;
         if (!bus3.pready && (bus3.pslverr !== 1'b0 || bus3.prdata !== 8'h00)) out_viol++;
      end
   end

   task automatic clear_model();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 64; i++) ref_mem[d][i] = 8'h00;
   endtask

   task automatic idle(input int n);
      psel = 1'b0; penable = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Entered and left at posedge+1; psel is left high so the caller may chain transfers.
   task automatic xfer(input bit wr, input logic [7:0] a, input logic [7:0] d,
                       output int ncyc, output logic [7:0] rd, output logic err);
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
      @(posedge clk); #1;
      penable = 1'b1;
      ncyc = 0; rd = 8'h00; err = 1'b0;
      while (1) begin
         @(negedge clk);
         ncyc++;
         if (pready_m) begin
            rd = prdata_m; err = pslverr_m;
            break;
         end
         if (ncyc > 40) begin
            chk("pready_timeout", ncyc, 0);
            break;
         end
         @(posedge clk); #1;
         paddr  = 8'($urandom);
         pwdata = 8'($urandom);
      end
      @(posedge clk); #1;
      penable = 1'b0;
   endtask

   task automatic do_xfer(input string tag, input bit wr, input logic [7:0] a, input logic [7:0] d);
      int         ncyc;
      logic [7:0] rd, rd_exp;
      logic       err, err_exp;
      int         di;
      di = dsel ? 1 : 0;
      xfer(wr, a, d, ncyc, rd, err);
      if (a < 8'd64) begin
         err_exp = 1'b0;
         if (wr) begin
            ref_mem[di][a[5:0]] = d;
            rd_exp = 8'h00;
         end else begin
            rd_exp = ref_mem[di][a[5:0]];
         end
      end else begin
         err_exp = 1'b1;
         rd_exp  = 8'h00;
      end
      chk({tag, "_cyc"}, ncyc, (dsel ? 3 : 0) + 2);
      chk({tag, "_rd"},  rd,   rd_exp);
      chk({tag, "_err"}, err,  err_exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         rdy;
      logic [7:0] a, dd;
      bit         wr;
      preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = 8'h00; pwdata = 8'h00; dsel = 1'b0;
      clear_model();
      @(posedge clk);
      @(negedge clk);
      chk("rst_pready0",  bus0.pready,  1'b0);
      chk("rst_pslverr0", bus0.pslverr, 1'b0);
      chk("rst_prdata0",  bus0.prdata,  8'h00);
      chk("rst_pready3",  bus3.pready,  1'b0);
      @(posedge clk); #1;
      preset = 1'b0;
      idle(1);

      // No-wait instance: basic write/read, unwritten location, out-of-range.
      dsel = 1'b0;
      do_xfer("w10", 1'b1, 8'h10, 8'hA5);
      do_xfer("r10", 1'b0, 8'h10, 8'h00);
      idle(1);
      do_xfer("r20", 1'b0, 8'h20, 8'h00);
      idle(1);
      do_xfer("w40_err", 1'b1, 8'h40, 8'hFF);
      idle(1);
      do_xfer("r40_err", 1'b0, 8'h40, 8'h00);
      idle(1);

      // Back-to-back with psel held high between transfers.
      do_xfer("b2b_w01", 1'b1, 8'h01, 8'h11);
      do_xfer("b2b_w02", 1'b1, 8'h02, 8'h22);
      do_xfer("b2b_r01", 1'b0, 8'h01, 8'h00);
      do_xfer("b2b_r02", 1'b0, 8'h02, 8'h00);
      idle(1);

      // penable raised straight from idle must never produce a response.
      rdy = 0;
      psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h01; pwdata = 8'hEE;
      repeat (3) begin
         @(negedge clk); rdy += int'(pready_m);
         @(posedge clk); #1;
      end
      chk("pen_idle_rdy", rdy, 0);
      idle(1);
      do_xfer("pen_idle_r01", 1'b0, 8'h01, 8'h00);
      idle(1);

      // Three-wait instance.
      dsel = 1'b1;
      do_xfer("w05", 1'b1, 8'h05, 8'h3C);
      idle(2);
      do_xfer("r05", 1'b0, 8'h05, 8'h00);
      idle(1);

      // psel dropped in the second wait cycle of a write.
      rdy = 0;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08; pwdata = 8'h77;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk); rdy += int'(pready_m);
         @(posedge clk); #1;
         if (k == 0) penable = 1'b1;
         if (k == 2) begin psel = 1'b0; penable = 1'b0; end
      end
      chk("abort_rdy", rdy, 0);
      do_xfer("abort_r08", 1'b0, 8'h08, 8'h00);
      idle(1);

      // Reset during the access wait of a write.
      do_xfer("pre_w03", 1'b1, 8'h03, 8'h55);
      idle(1);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h03; pwdata = 8'h99;
      @(posedge clk); #1; penable = 1'b1;
      @(posedge clk); #1; preset = 1'b1;
      @(posedge clk); #1; preset = 1'b0; psel = 1'b0; penable = 1'b0;
      clear_model();
      @(negedge clk);
      chk("rstmid_pready",  pready_m,  1'b0);
      chk("rstmid_pslverr", pslverr_m, 1'b0);
      chk("rstmid_prdata",  prdata_m,  8'h00);
      @(posedge clk); #1;
      do_xfer("rstmid_r03", 1'b0, 8'h03, 8'h00);
      idle(1);

      // Randomized traffic on both instances against the array model.
      for (int d = 0; d < 2; d++) begin
         dsel = d[0];
         for (int n = 0; n < 40; n++) begin
            a  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(64, 79)) : 8'($urandom_range(0, 15));
            wr = 1'($urandom);
            dd = 8'($urandom);
            do_xfer($sformatf("rnd%0d_%0d", d, n), wr, a, dd);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
         end
         idle(1);
      end

      chk("quiet_outputs", out_viol, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
